// File: rtl/aes_round_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_round_ctrl_pkg
// Brief   : Shared AES-128 definitions: FSM encodings, round count, RCON
//           table, S-box and the byte-level round transforms.
// Revision: 1.0 - initial release
// ============================================================================
package aes_round_ctrl_pkg;

    // Controller FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    // AES-128 round count
    localparam int c_AES_NR = 10;

    // Forward S-box, entry 0 in the most-significant byte
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return c_SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    // Round constant for rounds 1..10; any other index yields zero
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Multiply by x in GF(2^8)
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the state lives at [127-8i -: 8]; byte i is row i%4, column i/4
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    // Row r rotates left by r columns
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                o[127 - 8 * (4 * c + row) -: 8] =
                    s[127 - 8 * (4 * ((c + row) % 4) + row) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                   input logic [127:0] k);
        return s ^ k;
    endfunction

endpackage : aes_round_ctrl_pkg
`default_nettype wire

// File: rtl/aes_round_dp.sv
`default_nettype none
// ============================================================================
// Module  : aes_round_dp
// Brief   : Combinational AES round: SubBytes, ShiftRows, optional
//           MixColumns (skipped on the final round), AddRoundKey.
// Revision: 1.0 - initial release
// ============================================================================
module aes_round_dp
    import aes_round_ctrl_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         is_final,
    output logic [127:0] result
);

    logic [127:0] w_shifted;
    logic [127:0] w_mixed;

    // One full round of the cipher on the current state
    always_comb begin
        w_shifted = shift_rows(sub_bytes(state));
        w_mixed   = is_final ? w_shifted : mix_columns(w_shifted);
        result    = add_round_key(w_mixed, round_key);
    end

endmodule : aes_round_dp
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : aes_round_ctrl
// Brief   : Iterative AES-128 encryptor, one round per clock, with
//           valid/ready handshakes on input and output.
// Revision: 1.0 - initial release
// ============================================================================
module aes_round_ctrl
    import aes_round_ctrl_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    localparam logic [3:0] c_LAST_RND = 4'(NR);

    fsm_state_t   fsm_state;
    fsm_state_t   w_fsm_next;

    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [3:0]   rnd;
    logic         r_out_valid;
    logic [127:0] r_ciphertext;

    logic         w_accept;
    logic         w_last;
    logic [31:0]  w_temp;
    logic [127:0] w_next_key;
    logic [127:0] w_round_out;

    assign w_accept   = (fsm_state == ST_IDLE) && in_valid;
    assign w_last     = (fsm_state == ST_RUN) && (rnd == c_LAST_RND);
    assign out_valid  = r_out_valid;
    assign ciphertext = r_ciphertext;

    // Key expansion step: RotWord, SubWord, RCON into the top byte, then chain
    always_comb begin
        w_temp = {sbox(key_reg[23:16]), sbox(key_reg[15:8]),
                  sbox(key_reg[7:0]),   sbox(key_reg[31:24])}
               ^ {rcon(rnd), 24'h000000};
        w_next_key[127:96] = key_reg[127:96] ^ w_temp;
        w_next_key[95:64]  = key_reg[95:64]  ^ w_next_key[127:96];
        w_next_key[63:32]  = key_reg[63:32]  ^ w_next_key[95:64];
        w_next_key[31:0]   = key_reg[31:0]   ^ w_next_key[63:32];
    end

    aes_round_dp u_round_dp (
        .state     (state_reg),
        .round_key (w_next_key),
        .is_final  (rnd == c_LAST_RND),
        .result    (w_round_out)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_state <= ST_IDLE;
        end else begin
            fsm_state <= w_fsm_next;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        w_fsm_next = fsm_state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        case (fsm_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_fsm_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rnd == c_LAST_RND) begin
                    w_fsm_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_fsm_next = ST_IDLE;
                end
            end
            default: begin
                w_fsm_next = ST_IDLE;
            end
        endcase
    end

    // Round datapath, key schedule, round counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= '0;
            key_reg      <= '0;
            rnd          <= '0;
            r_out_valid  <= 1'b0;
            r_ciphertext <= '0;
        end else begin
            case (fsm_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        state_reg <= plaintext ^ key;
                        key_reg   <= key;
                        rnd       <= 4'd1;
                    end else begin
                        rnd       <= '0;
                    end
                end
                ST_RUN: begin
                    state_reg <= w_round_out;
                    key_reg   <= w_next_key;
                    if (w_last) begin
                        // Counter parks at the last round until DONE drains
                        r_ciphertext <= w_round_out;
                        r_out_valid  <= 1'b1;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    rnd <= '0;
                end
            endcase
        end
    end

endmodule : aes_round_ctrl
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_round_ctrl
// Brief   : Directed self-checking bench for aes_round_ctrl using the
//           FIPS-197 Appendix B and C.1 vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

    localparam logic [127:0] c_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_S0_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] c_S1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    int errors;
    int checks;

    aes_round_ctrl #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one block for a single accept edge
    task automatic accept_block(input logic [127:0] pt, input logic [127:0] k);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    // Count edges until out_valid, bounded
    task automatic wait_out(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 30) begin
            step();
            edges++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: in_ready=%b busy=%b out_valid=%b, need 1/0/0",
                     in_ready, busy, out_valid);
        end
        checks++;
        if (ciphertext !== 128'h0) begin
            errors++;
            $display("FAIL reset_ct: got %h need 0", ciphertext);
        end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_fips_b();
        int n;
        accept_block(c_PT_B, c_KEY_B);
        checks++;
        if (dut.state_reg !== c_S0_B) begin
            errors++;
            $display("FAIL b_state_accept: got %h need %h", dut.state_reg, c_S0_B);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b_busy: busy=%b in_ready=%b need 1/0", busy, in_ready);
        end
        step();
        checks++;
        if (dut.state_reg !== c_S1_B) begin
            errors++;
            $display("FAIL b_state_round1: got %h need %h", dut.state_reg, c_S1_B);
        end
        wait_out(n);
        checks++;
        if (n + 1 != 10) begin
            errors++;
            $display("FAIL b_latency: got %0d edges need 10", n + 1);
        end
        checks++;
        if (ciphertext !== c_CT_B) begin
            errors++;
            $display("FAIL b_ct: got %h need %h", ciphertext, c_CT_B);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b_release: out_valid=%b in_ready=%b busy=%b need 0/1/0",
                     out_valid, in_ready, busy);
        end
        checks++;
        if (ciphertext !== c_CT_B) begin
            errors++;
            $display("FAIL b_ct_hold: got %h need %h", ciphertext, c_CT_B);
        end
    endtask

    task automatic test_fips_c();
        int n;
        accept_block(c_PT_C, c_KEY_C);
        wait_out(n);
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL c_latency: got %0d edges need 10", n);
        end
        checks++;
        if (ciphertext !== c_CT_C) begin
            errors++;
            $display("FAIL c_ct: got %h need %h", ciphertext, c_CT_C);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int n;
        accept_block(c_PT_B, c_KEY_B);
        wait_out(n);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                plaintext = c_PT_C;
                key       = c_KEY_C;
                in_valid  = 1'b1;
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || ciphertext !== c_CT_B || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b ct=%h need 1/0/%h",
                         i, out_valid, in_ready, ciphertext, c_CT_B);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b need 0/1", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: busy=%b in_ready=%b need 1/0", busy, in_ready);
        end
        wait_out(n);
        checks++;
        if (n != 10 || ciphertext !== c_CT_C) begin
            errors++;
            $display("FAIL bp_second_ct: edges=%0d ct=%h need 10/%h", n, ciphertext, c_CT_C);
        end
        handshake();
    endtask

    task automatic test_reset_mid_run();
        int  n;
        logic seen;
        accept_block(c_PT_B, c_KEY_B);
        repeat (4) step();
        checks++;
        if (dut.rnd !== 4'd5) begin
            errors++;
            $display("FAIL rr_round: got %0d need 5", dut.rnd);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ciphertext !== 128'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_immediate: out_valid=%b ct=%h in_ready=%b busy=%b need 0/0/1/0",
                     out_valid, ciphertext, in_ready, busy);
        end
        checks++;
        if (dut.state_reg !== 128'h0 || dut.key_reg !== 128'h0) begin
            errors++;
            $display("FAIL rr_regs: state=%h key=%h need 0/0", dut.state_reg, dut.key_reg);
        end
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rr_discard: out_valid_seen=%b in_ready=%b need 0/1", seen, in_ready);
        end
        accept_block(c_PT_B, c_KEY_B);
        wait_out(n);
        checks++;
        if (n != 10 || ciphertext !== c_CT_B) begin
            errors++;
            $display("FAIL rr_rerun: edges=%0d ct=%h need 10/%h", n, ciphertext, c_CT_B);
        end
        handshake();
    endtask

    task automatic test_ignore_inputs();
        int n;
        accept_block(c_PT_C, c_KEY_C);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            step();
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ign_in_ready[%0d]: got %b need 0", i, in_ready);
            end
        end
        in_valid = 1'b0;
        wait_out(n);
        checks++;
        if (n != 5 || ciphertext !== c_CT_C) begin
            errors++;
            $display("FAIL ign_ct: edges=%0d ct=%h need 5/%h", n, ciphertext, c_CT_C);
        end
        handshake();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        key       = '0;
        test_reset();
        test_fips_b();
        test_fips_c();
        test_backpressure();
        test_reset_mid_run();
        test_ignore_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_aes_round_ctrl
`default_nettype wire
